// File: rtl/spi_cmd_master_if.sv
// Command-side bundle between the synth controller and spi_cmd_master.
// The controller uses the master modport and the SPI engine uses the slave modport.
interface spi_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rx_byte;
  logic        rx_valid;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, busy, done, err, rx_byte, rx_valid
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, busy, done, err, rx_byte, rx_valid
  );
endinterface

// File: rtl/spi_cmd_master.sv
// SPI mode-0 master that sends synth control frames (opcode + payload bytes)
// to the DDS voice engine under one NSS assertion, and returns each byte seen
// on MISO so the controller can check the slave's echo.
module spi_cmd_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int NSS_SETUP  = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  spi_cmd_master_if.slave cmd_if,
  output logic            o_spi_nss,
  output logic            o_spi_sclk,
  output logic            o_spi_mosi,
  input  logic            i_spi_miso
);

  localparam int MAX_CNT =
    (CLK_DIV > GAP_CYCLES) ? ((CLK_DIV > NSS_SETUP) ? CLK_DIV : NSS_SETUP)
                           : ((GAP_CYCLES > NSS_SETUP) ? GAP_CYCLES : NSS_SETUP);
  localparam int DW = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [DW-1:0] DIV_LOAD   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LOAD   = DW'(GAP_CYCLES - 1);
  localparam logic [DW-1:0] SETUP_LOAD = DW'(NSS_SETUP - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  localparam logic [7:0] OP_FREQ = 8'd1;
  localparam logic [7:0] OP_ENV  = 8'd2;

  logic [2:0]    r_state;
  logic [DW-1:0] r_div;
  logic          r_phase;
  logic [2:0]    r_bit_cnt;
  logic [1:0]    r_byte_cnt;
  logic [7:0]    r_shift;
  logic [15:0]   r_data;
  logic [7:0]    r_rx;
  logic          r_miso_s1;
  logic          r_miso_s2;
  logic          r_nss;
  logic          r_sclk;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [7:0]    r_rx_byte;
  logic          r_rx_valid;

  logic       w_ready;
  logic       w_accept;
  logic       w_op_ok;
  logic [7:0] w_next_byte;

  // r_byte_cnt holds the bytes still to send after the current one; with one
  // left the next byte is always the low payload byte, with two it is the high.
  assign w_ready     = (r_state == S_IDLE) && !i_reset;
  assign w_accept    = cmd_if.cmd_valid && w_ready;
  assign w_op_ok     = (cmd_if.cmd_op == OP_FREQ) || (cmd_if.cmd_op == OP_ENV);
  assign w_next_byte = (r_byte_cnt == 2'd2) ? r_data[15:8] : r_data[7:0];

  assign cmd_if.cmd_ready = w_ready;
  assign cmd_if.busy      = r_busy;
  assign cmd_if.done      = r_done;
  assign cmd_if.err       = r_err;
  assign cmd_if.rx_byte   = r_rx_byte;
  assign cmd_if.rx_valid  = r_rx_valid;

  // MOSI is the top bit of the shift register, so it stays a registered pin.
  assign o_spi_nss  = r_nss;
  assign o_spi_sclk = r_sclk;
  assign o_spi_mosi = r_shift[7];

  // Two-flop synchronizer for the asynchronous MISO pin.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= i_spi_miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  // Frame sequencer: accept, NSS lead, bit shifting, inter-byte gap, NSS lag, recovery.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_phase    <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 2'd0;
      r_shift    <= 8'h00;
      r_data     <= 16'h0000;
      r_rx       <= 8'h00;
      r_nss      <= 1'b1;
      r_sclk     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_op_ok) begin
              r_state    <= S_SETUP;
              r_nss      <= 1'b0;
              r_busy     <= 1'b1;
              r_shift    <= cmd_if.cmd_op;
              r_data     <= cmd_if.cmd_data;
              r_byte_cnt <= (cmd_if.cmd_op == OP_FREQ) ? 2'd2 : 2'd1;
              r_div      <= SETUP_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          if (r_div == '0) begin
            r_state   <= S_SHIFT;
            r_phase   <= 1'b0;
            r_bit_cnt <= 3'd7;
            r_div     <= DIV_LOAD;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end

        S_SHIFT: begin
          if (r_div != '0) begin
            r_div <= r_div - 1'b1;
          end else if (!r_phase) begin
            r_phase <= 1'b1;
            r_sclk  <= 1'b1;
            r_rx    <= {r_rx[6:0], r_miso_s2};
            r_div   <= DIV_LOAD;
          end else begin
            r_phase <= 1'b0;
            r_sclk  <= 1'b0;
            if (r_bit_cnt != 3'd0) begin
              r_bit_cnt <= r_bit_cnt - 3'd1;
              r_shift   <= {r_shift[6:0], 1'b0};
              r_div     <= DIV_LOAD;
            end else begin
              r_rx_byte  <= r_rx;
              r_rx_valid <= 1'b1;
              if (r_byte_cnt != 2'd0) begin
                r_state    <= S_GAP;
                r_shift    <= w_next_byte;
                r_byte_cnt <= r_byte_cnt - 2'd1;
                r_div      <= GAP_LOAD;
              end else begin
                r_state <= S_HOLD;
                r_shift <= 8'h00;
                r_div   <= SETUP_LOAD;
              end
            end
          end
        end

        S_GAP: begin
          if (r_div == '0) begin
            r_state   <= S_SHIFT;
            r_phase   <= 1'b0;
            r_bit_cnt <= 3'd7;
            r_div     <= DIV_LOAD;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end

        S_HOLD: begin
          if (r_div == '0) begin
            r_state <= S_RECOVER;
            r_nss   <= 1'b1;
            r_done  <= 1'b1;
            r_div   <= SETUP_LOAD;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end

        S_RECOVER: begin
          if (r_div == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_nss   <= 1'b1;
          r_sclk  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Testbench for spi_cmd_master: a default-parameter instance exercised with a
// vector table plus back-to-back and mid-frame reset sequences, and a fast
// instance (CLK_DIV=2, GAP_CYCLES=1, NSS_SETUP=1) checked for phase timing.
module tb_spi_cmd_master;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] data;
    int          nBytes;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          nssLow;
    logic [7:0]  rxFirst;
    logic [7:0]  rxLast;
  } vec_t;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic spiMiso = 1'b0;
  logic spiNss, spiSclk, spiMosi;
  logic spiNss2, spiSclk2, spiMosi2;

  int assertCnt = 0;
  int failCnt   = 0;

  spi_cmd_master_if cmdIf();
  spi_cmd_master_if cmdIf2();

  spi_cmd_master dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .cmd_if     (cmdIf),
    .o_spi_nss  (spiNss),
    .o_spi_sclk (spiSclk),
    .o_spi_mosi (spiMosi),
    .i_spi_miso (spiMiso)
  );

  spi_cmd_master #(.CLK_DIV(2), .GAP_CYCLES(1), .NSS_SETUP(1)) dutFast (
    .i_clk      (clk),
    .i_reset    (reset),
    .cmd_if     (cmdIf2),
    .o_spi_nss  (spiNss2),
    .o_spi_sclk (spiSclk2),
    .o_spi_mosi (spiMosi2),
    .i_spi_miso (1'b0)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Monitor and SPI slave model for the default instance. It runs on the
  // falling clock edge, counts pin activity and pulses, logs every byte seen
  // on MOSI, and answers on MISO with the previous byte it received (echo).
  int nssLowCnt = 0, lastNssLow = 0, nssHighCnt = 0, lastNssHigh = 0;
  int nssFalls = 0, sclkRises = 0, mosiToggles = 0;
  int doneCnt = 0, doneAtRise = 0, errCnt = 0, rxCnt = 0, rxAtFall = 0;
  int mosiCnt = 0, slvBits = 0, sinceRise = 0, riseToReady = 0;
  logic prevNss = 1'b1, prevSclk = 1'b0, prevMosi = 1'b0, prevReady = 1'b0;
  logic [7:0] slvIn = 8'h00, slvOut = 8'h00, slvEcho = 8'h00;
  logic [7:0] mosiLog [64];
  logic [7:0] rxLog [64];

  always @(negedge clk) begin
    if (prevNss && !spiNss) begin
      nssFalls++;
      lastNssHigh = nssHighCnt;
      nssLowCnt   = 1;
      slvBits     = 0;
      slvOut      = slvEcho;
      spiMiso     = slvEcho[7];
    end else if (spiNss === 1'b0) begin
      nssLowCnt++;
    end
    if (!prevNss && spiNss) begin
      lastNssLow = nssLowCnt;
      nssHighCnt = 1;
      sinceRise  = 0;
      if (cmdIf.done) doneAtRise++;
    end else begin
      if (spiNss === 1'b1) nssHighCnt++;
      sinceRise++;
    end
    if (cmdIf.cmd_ready && !prevReady) riseToReady = sinceRise;
    if (!prevSclk && spiSclk && !spiNss) begin
      sclkRises++;
      slvIn = {slvIn[6:0], spiMosi};
      slvBits++;
      if (slvBits == 8) begin
        mosiLog[mosiCnt % 64] = slvIn;
        mosiCnt++;
        slvEcho = slvIn;
        slvBits = 0;
      end
    end
    if (prevSclk && !spiSclk && !spiNss) begin
      if (slvBits == 0) slvOut = slvEcho;
      else slvOut = {slvOut[6:0], 1'b0};
      spiMiso = slvOut[7];
    end
    if (spiMosi != prevMosi) mosiToggles++;
    if (cmdIf.done) doneCnt++;
    if (cmdIf.err) errCnt++;
    if (cmdIf.rx_valid) begin
      rxLog[rxCnt % 64] = cmdIf.rx_byte;
      rxCnt++;
      if (prevSclk && !spiSclk) rxAtFall++;
    end
    prevNss   = spiNss;
    prevSclk  = spiSclk;
    prevMosi  = spiMosi;
    prevReady = cmdIf.cmd_ready;
  end

  // Monitor for the fast instance: NSS-low length, SCLK high/low run lengths
  // inside bytes, rising-edge count and the bits seen on MOSI.
  int nssLow2 = 0, lastNssLow2 = 0, rises2 = 0, done2 = 0;
  int highRun2 = 0, lowRun2 = 0, minHigh2 = 999, maxHigh2 = 0, lowTwo2 = 0;
  logic prevNss2 = 1'b1, prevSclk2 = 1'b0;
  logic [23:0] mosiWord2 = 24'h0;

  always @(negedge clk) begin
    if (prevNss2 && !spiNss2) nssLow2 = 1;
    else if (spiNss2 === 1'b0) nssLow2++;
    if (!prevNss2 && spiNss2) lastNssLow2 = nssLow2;
    if (spiSclk2 === 1'b1) begin
      highRun2++;
      if (!prevSclk2) begin
        rises2++;
        mosiWord2 = {mosiWord2[22:0], spiMosi2};
        if (lowRun2 == 2) lowTwo2++;
        lowRun2 = 0;
      end
    end else begin
      lowRun2++;
      if (prevSclk2) begin
        if (highRun2 < minHigh2) minHigh2 = highRun2;
        if (highRun2 > maxHigh2) maxHigh2 = highRun2;
        highRun2 = 0;
      end
    end
    if (cmdIf2.done) done2++;
    prevNss2  = spiNss2;
    prevSclk2 = spiSclk2;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCnt++;
    if (actual !== expected) begin
      failCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [15:0] data);
    int n = 0;
    @(negedge clk);
    while (cmdIf.cmd_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("readyBeforeCmd", 32'(n < 3000), 1);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = op;
    cmdIf.cmd_data  = data;
    @(posedge clk);
    #1;
    cmdIf.cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    @(negedge clk);
    while (cmdIf.cmd_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(n < 3000), 1);
  endtask

  initial begin
    vec_t vecs [7];
    int d0, e0, f0, m0, r0, s0, t0, a0, x0, n;

    vecs[0] = '{8'h01, 16'h1234, 3, 8'h01, 8'h12, 8'h34, 216, 8'h00, 8'h12};
    vecs[1] = '{8'h02, 16'h00A5, 2, 8'h02, 8'hA5, 8'h00, 144, 8'h34, 8'h02};
    vecs[2] = '{8'h07, 16'hFFFF, 0, 8'h00, 8'h00, 8'h00, 0,   8'h00, 8'h00};
    vecs[3] = '{8'h02, 16'hBEEF, 2, 8'h02, 8'hEF, 8'h00, 144, 8'hA5, 8'h02};
    vecs[4] = '{8'h00, 16'h1111, 0, 8'h00, 8'h00, 8'h00, 0,   8'h00, 8'h00};
    vecs[5] = '{8'h01, 16'hA55A, 3, 8'h01, 8'hA5, 8'h5A, 216, 8'hEF, 8'hA5};
    vecs[6] = '{8'hFF, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 0,   8'h00, 8'h00};

    cmdIf.cmd_valid  = 1'b0;
    cmdIf.cmd_op     = 8'h00;
    cmdIf.cmd_data   = 16'h0000;
    cmdIf2.cmd_valid = 1'b0;
    cmdIf2.cmd_op    = 8'h00;
    cmdIf2.cmd_data  = 16'h0000;

    // Reset state.
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("rstNss", spiNss, 1);
    checkOutput("rstSclk", spiSclk, 0);
    checkOutput("rstMosi", spiMosi, 0);
    checkOutput("rstBusy", cmdIf.busy, 0);
    checkOutput("rstDone", cmdIf.done, 0);
    checkOutput("rstErr", cmdIf.err, 0);
    checkOutput("rstRxValid", cmdIf.rx_valid, 0);
    checkOutput("rstRxByte", cmdIf.rx_byte, 8'h00);
    checkOutput("rstReady", cmdIf.cmd_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("readyAfterRst", cmdIf.cmd_ready, 1);

    // Table-driven commands.
    for (int v = 0; v < 7; v++) begin
      d0 = doneCnt; e0 = errCnt; f0 = nssFalls; m0 = mosiCnt;
      r0 = rxCnt; s0 = sclkRises; t0 = mosiToggles; a0 = doneAtRise; x0 = rxAtFall;
      applyStimulus(vecs[v].op, vecs[v].data);
      if (vecs[v].nBytes > 0) begin
        checkOutput($sformatf("v%0d_nssFall", v), spiNss, 0);
        checkOutput($sformatf("v%0d_busy", v), cmdIf.busy, 1);
        checkOutput($sformatf("v%0d_readyLow", v), cmdIf.cmd_ready, 0);
      end else begin
        checkOutput($sformatf("v%0d_errPulse", v), cmdIf.err, 1);
        checkOutput($sformatf("v%0d_readyHigh", v), cmdIf.cmd_ready, 1);
        checkOutput($sformatf("v%0d_errBusy", v), cmdIf.busy, 0);
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_errOneCycle", v), cmdIf.err, 0);
      end
      waitIdle($sformatf("v%0d_idleTimeout", v));
      repeat (2) @(negedge clk);
      checkOutput($sformatf("v%0d_done", v), doneCnt - d0, (vecs[v].nBytes > 0) ? 1 : 0);
      checkOutput($sformatf("v%0d_err", v), errCnt - e0, (vecs[v].nBytes > 0) ? 0 : 1);
      checkOutput($sformatf("v%0d_frames", v), nssFalls - f0, (vecs[v].nBytes > 0) ? 1 : 0);
      checkOutput($sformatf("v%0d_sclkRises", v), sclkRises - s0, 8 * vecs[v].nBytes);
      checkOutput($sformatf("v%0d_rxCount", v), rxCnt - r0, vecs[v].nBytes);
      if (vecs[v].nBytes > 0) begin
        checkOutput($sformatf("v%0d_nssLow", v), lastNssLow, vecs[v].nssLow);
        checkOutput($sformatf("v%0d_doneAtNssRise", v), doneAtRise - a0, 1);
        checkOutput($sformatf("v%0d_rxAtSclkFall", v), rxAtFall - x0, vecs[v].nBytes);
        checkOutput($sformatf("v%0d_riseToReady", v), riseToReady, 4);
        checkOutput($sformatf("v%0d_byte0", v), mosiLog[m0 % 64], vecs[v].b0);
        checkOutput($sformatf("v%0d_byte1", v), mosiLog[(m0 + 1) % 64], vecs[v].b1);
        if (vecs[v].nBytes > 2)
          checkOutput($sformatf("v%0d_byte2", v), mosiLog[(m0 + 2) % 64], vecs[v].b2);
        checkOutput($sformatf("v%0d_rxFirst", v), rxLog[r0 % 64], vecs[v].rxFirst);
        checkOutput($sformatf("v%0d_rxLast", v), rxLog[(r0 + vecs[v].nBytes - 1) % 64],
                    vecs[v].rxLast);
        checkOutput($sformatf("v%0d_rxByteOut", v), cmdIf.rx_byte, vecs[v].rxLast);
      end else begin
        checkOutput($sformatf("v%0d_mosiQuiet", v), mosiToggles - t0, 0);
      end
    end

    // Back-to-back: cmd_valid held high across two commands.
    d0 = doneCnt; f0 = nssFalls; m0 = mosiCnt; r0 = rxCnt; s0 = sclkRises;
    @(negedge clk);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = 8'h01;
    cmdIf.cmd_data  = 16'h3C96;
    @(posedge clk);
    #1;
    @(negedge clk);
    cmdIf.cmd_op   = 8'h02;
    cmdIf.cmd_data = 16'h0077;
    n = 0;
    while (nssFalls - f0 < 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    cmdIf.cmd_valid = 1'b0;
    checkOutput("b2b_secondAccept", 32'(n < 3000), 1);
    waitIdle("b2b_idleTimeout");
    repeat (4) @(negedge clk);
    checkOutput("b2b_frames", nssFalls - f0, 2);
    checkOutput("b2b_done", doneCnt - d0, 2);
    checkOutput("b2b_sclkRises", sclkRises - s0, 40);
    checkOutput("b2b_nssHighGap", lastNssHigh, 5);
    checkOutput("b2b_nssLow2nd", lastNssLow, 144);
    checkOutput("b2b_byte0", mosiLog[m0 % 64], 8'h01);
    checkOutput("b2b_byte1", mosiLog[(m0 + 1) % 64], 8'h3C);
    checkOutput("b2b_byte2", mosiLog[(m0 + 2) % 64], 8'h96);
    checkOutput("b2b_byte3", mosiLog[(m0 + 3) % 64], 8'h02);
    checkOutput("b2b_byte4", mosiLog[(m0 + 4) % 64], 8'h77);
    checkOutput("b2b_rxCount", rxCnt - r0, 5);
    checkOutput("b2b_rx3", rxLog[(r0 + 3) % 64], 8'h96);
    checkOutput("b2b_rx4", rxLog[(r0 + 4) % 64], 8'h02);

    // Reset in the middle of byte 1 of an op 1 frame, with cmd_valid also high.
    d0 = doneCnt; f0 = nssFalls; m0 = mosiCnt; r0 = rxCnt;
    applyStimulus(8'h01, 16'hC3E1);
    n = 0;
    while (rxCnt - r0 < 1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_byte0Timeout", 32'(n < 3000), 1);
    repeat (20) @(negedge clk);
    reset           = 1'b1;
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = 8'h02;
    cmdIf.cmd_data  = 16'h0042;
    @(posedge clk);
    #1;
    checkOutput("rst_nss", spiNss, 1);
    checkOutput("rst_sclk", spiSclk, 0);
    checkOutput("rst_busy", cmdIf.busy, 0);
    checkOutput("rst_readyLow", cmdIf.cmd_ready, 0);
    @(negedge clk);
    reset           = 1'b0;
    cmdIf.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_noAcceptNss", spiNss, 1);
    checkOutput("rst_noAcceptBusy", cmdIf.busy, 0);
    repeat (20) @(negedge clk);
    checkOutput("rst_noDone", doneCnt - d0, 0);
    checkOutput("rst_rxOnlyByte0", rxCnt - r0, 1);
    checkOutput("rst_rxByte0", rxLog[r0 % 64], 8'h77);
    checkOutput("rst_oneFrame", nssFalls - f0, 1);
    applyStimulus(8'h02, 16'h0042);
    waitIdle("rst_idleTimeout");
    repeat (2) @(negedge clk);
    checkOutput("rst_nextDone", doneCnt - d0, 1);
    checkOutput("rst_nextNssLow", lastNssLow, 144);
    checkOutput("rst_nextByte0", mosiLog[(m0 + 1) % 64], 8'h02);
    checkOutput("rst_nextByte1", mosiLog[(m0 + 2) % 64], 8'h42);
    checkOutput("rst_nextRx0", rxLog[(r0 + 1) % 64], 8'h01);
    checkOutput("rst_nextRx1", rxLog[(r0 + 2) % 64], 8'h02);
    checkOutput("rst_nextRxCount", rxCnt - r0, 3);

    // Fast instance: op 1 frame with minimum timing parameters.
    @(negedge clk);
    cmdIf2.cmd_valid = 1'b1;
    cmdIf2.cmd_op    = 8'h01;
    cmdIf2.cmd_data  = 16'hABCD;
    @(posedge clk);
    #1;
    cmdIf2.cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (cmdIf2.cmd_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fast_idleTimeout", 32'(n < 3000), 1);
    repeat (2) @(negedge clk);
    checkOutput("fast_nssLow", lastNssLow2, 100);
    checkOutput("fast_sclkRises", rises2, 24);
    checkOutput("fast_minHigh", minHigh2, 2);
    checkOutput("fast_maxHigh", maxHigh2, 2);
    checkOutput("fast_lowPhases", lowTwo2, 21);
    checkOutput("fast_mosiBits", mosiWord2, 24'h01ABCD);
    checkOutput("fast_done", done2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/spi_cmd_master.md
# spi_cmd_master

SPI master that issues synth control frames (frequency and envelope updates) to the DDS voice engine's SPI slave port. It accepts one command per request over a valid/ready handshake and serializes it MSB-first in SPI mode 0. The frame is an opcode byte followed by its payload bytes, all sent under a single chip-select assertion. Bytes shifted in on MISO are returned one at a time so the controller side can check the slave's echo.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range is 2 or more.
- GAP_CYCLES, 8: idle clk cycles between bytes inside a frame, with SCLK low and NSS low; legal range is 1 or more.
- NSS_SETUP, 4: clk cycles of NSS-low lead before the first bit and lag after the last bit, and also the minimum NSS-high recovery time; legal range is 1 or more.
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  8  opcode: 1 = frequency update, 2 = envelope update.
- cmd_data  in  16  payload; sampled at accept.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  1  one-cycle pulse when an opcode is rejected.
- rx_byte  out  8  last byte captured from MISO.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- spi_nss  out  1  chip select, active low.
- spi_sclk  out  1  serial clock; idles low.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in; the block synchronizes it with 2 flops before use.

## Operation
- Accept: a command is accepted when cmd_valid and cmd_ready are both high. cmd_op and cmd_data are registered on that cycle.
- Byte sequence for op 1: 3 bytes, in order op, cmd_data[15:8], cmd_data[7:0].
- Byte sequence for op 2: 2 bytes, in order op, cmd_data[7:0].
- Any other opcode: the command is still accepted, no frame is sent, err pulses the next cycle, and the block stays in IDLE.
- State IDLE: NSS high, SCLK low. Exit to SETUP on accept of a valid opcode.
- State SETUP: NSS low, MOSI driven with bit 7 of byte 0. Lasts NSS_SETUP cycles, then goes to SHIFT.
- State SHIFT: for each of 8 bits, SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MISO is sampled on the cycle SCLK goes high.
  - MOSI advances to the next bit on the cycle SCLK goes low.
  - After bit 0's high phase: SCLK returns low, rx_byte is loaded, and rx_valid pulses.
  - Next state is GAP if bytes remain, otherwise HOLD.
- State GAP: NSS low, SCLK low, MOSI holds bit 7 of the next byte. Lasts GAP_CYCLES cycles, then returns to SHIFT.
- State HOLD: NSS low, SCLK low. Lasts NSS_SETUP cycles, then goes to RECOVER and done pulses on the entry cycle.
- State RECOVER: NSS high. Lasts NSS_SETUP cycles, then goes to IDLE.
- Counters:
  - Byte counter: 2 bits, counts down to 0.
  - Bit counter: 3 bits.
  - Divider: sized for the largest of CLK_DIV, GAP_CYCLES and NSS_SETUP; reloads on every state or phase change.
- Reset:
  - Outputs: spi_nss=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, err=0, rx_valid=0, rx_byte=0x00, state IDLE.
  - cmd_ready is 0 while reset is high.
  - Reset during a frame: NSS goes high on the next edge, and neither done nor rx_valid is issued for the partial byte.

## Timing
- All SPI outputs are registered, so there are no combinational paths from inputs to pins.
- NSS falls on the first clk edge after accept. busy goes high on that same edge.
- NSS-low duration = 2·NSS_SETUP + n·16·CLK_DIV + (n−1)·GAP_CYCLES, where n is the byte count.
  - Defaults, op 1: 4 + 4 + 192 + 16 = 216 cycles.
  - Defaults, op 2: 4 + 4 + 128 + 8 = 144 cycles.
- done pulses on the same edge that NSS rises.
- cmd_ready returns NSS_SETUP cycles after NSS rises. busy drops on that same edge.
- rx_valid pulses once per byte, on the same edge that the byte's final SCLK falling edge is driven.
- cmd_valid while busy is ignored. No command is queued.
- Simultaneous reset and cmd_valid: reset wins and nothing is accepted.

## Test plan
- Op 1 with cmd_data=0x1234, defaults: MOSI carries 0x01, 0x12, 0x34 MSB-first; NSS is low for exactly 216 cycles; 24 SCLK rising edges; done pulses once.
- Op 2 with cmd_data=0x00A5, and the slave model echoing the previous byte: MOSI carries 0x02, 0xA5; rx_valid pulses twice and rx_byte ends at 0x02; NSS is low for 144 cycles.
- Op 7: err pulses one cycle after accept; NSS, SCLK and MOSI never toggle; cmd_ready is high again the next cycle.
- Back-to-back: cmd_valid held high with op 1, then op 2; NSS-high gap between the frames ≥ NSS_SETUP (4 cycles); the second frame is correct; no command is dropped or duplicated.
- Reset asserted during byte 1 of an op 1 frame: NSS=1 and SCLK=0 on the next edge; no done; rx_valid does not pulse for the cut byte; a subsequent op 2 frame is clean.
- CLK_DIV=2, GAP_CYCLES=1, NSS_SETUP=1: each SCLK high and low phase is 2 cycles; NSS-low duration = 2 + 96 + 2 = 100 cycles for op 1.
